// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// The default request layout matches the default 32-bit data / 5-bit index configuration.
package wb_arb_pkg;

    localparam int WB_DEF_DATA_W = 32;
    localparam int WB_DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } wb_arb_state_t;

    typedef struct packed {
        logic [WB_DEF_ADDR_W-1:0] rd;
        logic [WB_DEF_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback-side and long-latency-side signals around the register-file write port.
// The slave modport is the arbiter; the master modport is the pipeline, requester and register file.
interface wb_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  RegWriteW;
    logic [ADDR_WIDTH-1:0] RdW;
    logic [DATA_WIDTH-1:0] ResultW;
    logic                  LongValid;
    logic                  LongReady;
    logic [ADDR_WIDTH-1:0] LongRd;
    logic [DATA_WIDTH-1:0] LongData;
    logic                  WE3;
    logic [ADDR_WIDTH-1:0] A3;
    logic [DATA_WIDTH-1:0] WD3;
    logic                  StallW;

    modport master (
        output RegWriteW, RdW, ResultW, LongValid, LongRd, LongData,
        input  LongReady, WE3, A3, WD3, StallW
    );

    modport slave (
        input  RegWriteW, RdW, ResultW, LongValid, LongRd, LongData,
        output LongReady, WE3, A3, WD3, StallW
    );
endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Small synchronous queue of pending long-latency results.
// Exposes every slot plus a valid mask so the parent can look for destination clashes.
module wb_req_fifo
    import wb_arb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wb_req_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  T                           i_din,
    output T                           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output T     [DEPTH-1:0]           o_mem,
    output logic [DEPTH-1:0]           o_vld
);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    T     [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [NW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == NW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign o_mem   = r_mem;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + NW'(1);
                2'b01:   r_count <= r_count - NW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: the valid mask and count decide what is live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_vld
        logic [PW-1:0] w_off;
        assign w_off    = PW'(i) - r_rptr;
        assign o_vld[i] = (NW'(w_off) < r_count);
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order W stage (fixed priority)
// and a queue of long-latency results; forces a one-cycle W stall when a result starves.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    wb_arb_state_t          r_state;
    logic [CW-1:0]          r_wait_cnt;
    logic [CW-1:0]          w_cnt_inc;

    req_t                   w_din;
    req_t                   w_head;
    req_t [FIFO_DEPTH-1:0]  w_mem;
    logic [FIFO_DEPTH-1:0]  w_vld;
    logic [FIFO_DEPTH-1:0]  w_clash;
    logic [NW-1:0]          w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pipe_use;
    logic                   w_grant;
    logic                   w_last;

    assign w_din.rd   = bus.LongRd;
    assign w_din.data = bus.LongData;

    assign bus.LongReady = rst_n & ~w_full;
    assign w_push        = bus.LongValid & bus.LongReady;

    // During FORCE the W stage is held, so its write is ignored and re-presented next cycle.
    assign w_pipe_use = bus.RegWriteW & (bus.RdW != '0) & (r_state != FORCE);
    assign w_grant    = ~w_empty & ~w_pipe_use;
    assign w_last     = (w_count == NW'(1)) & ~w_push;
    assign w_cnt_inc  = (r_wait_cnt == MAX_CNT) ? MAX_CNT : r_wait_cnt + CW'(1);

    assign bus.StallW = rst_n & (r_state == FORCE);

    wb_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_grant),
        .i_din   (w_din),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_mem   (w_mem),
        .o_vld   (w_vld)
    );

    always_comb begin
        bus.WE3 = 1'b0;
        bus.A3  = '0;
        bus.WD3 = '0;
        if (rst_n) begin
            if (w_pipe_use) begin
                bus.WE3 = 1'b1;
                bus.A3  = bus.RdW;
                bus.WD3 = bus.ResultW;
            end else if (w_grant) begin
                // An x0 entry still pops; it just never reaches the file.
                bus.WE3 = (w_head.rd != '0);
                bus.A3  = w_head.rd;
                bus.WD3 = w_head.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_wait_cnt <= '0;
                    if (w_push) r_state <= WAIT;
                end
                WAIT: begin
                    if (w_grant) begin
                        r_wait_cnt <= '0;
                        if (w_last) r_state <= IDLE;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                        if (w_cnt_inc == MAX_CNT) r_state <= FORCE;
                    end
                end
                FORCE: begin
                    r_wait_cnt <= '0;
                    r_state    <= w_last ? IDLE : WAIT;
                end
                default: begin
                    r_wait_cnt <= '0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    // Same-rd ordering belongs to the scoreboard; flag it if it ever slips through.
    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_clash
        assign w_clash[i] = w_vld[i] & (w_mem[i].rd == bus.RdW);
    end

    a_no_rd_clash: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_pipe_use && (w_clash != '0)));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter: one vector per cycle, outputs sampled on the falling edge.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    wb_port_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .FIFO_DEPTH (2),
        .MAX_WAIT   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        st;
        logic        rdy;
    } vec_t;

    function automatic vec_t mk(logic rw, logic [4:0] rd, logic [31:0] res,
                                logic lv, logic [4:0] lrd, logic [31:0] ld,
                                logic we, logic [4:0] a3, logic [31:0] wd,
                                logic st, logic rdy);
        vec_t v;
        v.rw = rw; v.rd = rd; v.res = res; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.we = we; v.a3 = a3; v.wd = wd; v.st = st; v.rdy = rdy;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.RegWriteW = v.rw;
        bus.RdW       = v.rd;
        bus.ResultW   = v.res;
        bus.LongValid = v.lv;
        bus.LongRd    = v.lrd;
        bus.LongData  = v.ld;
    endtask

    task automatic cmp(input vec_t v, input string nm);
        n_chk++;
        if ({bus.WE3, bus.A3, bus.WD3, bus.StallW, bus.LongReady} ===
            {v.we, v.a3, v.wd, v.st, v.rdy}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got we=%0b a3=%0d wd=%h stall=%0b rdy=%0b, want we=%0b a3=%0d wd=%h stall=%0b rdy=%0b",
                     nm, bus.WE3, bus.A3, bus.WD3, bus.StallW, bus.LongReady,
                     v.we, v.a3, v.wd, v.st, v.rdy);
        end
    endtask

    task automatic step(input vec_t v, input string nm);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        cmp(v, nm);
    endtask

    vec_t tbl[19];
    vec_t zero_rdy;
    vec_t zero_nrdy;

    initial begin
        zero_rdy  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        zero_nrdy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // idle port: accept then write next cycle
        tbl[0]  = mk(0, 0, 0,        1, 7, 32'hDEADBEEF, 0, 0, 0,            0, 1);
        tbl[1]  = mk(0, 0, 0,        0, 0, 0,            1, 7, 32'hDEADBEEF, 0, 1);
        tbl[2]  = zero_rdy;
        // pipeline priority: 4 blocked cycles, then forced drain, then held W write
        tbl[3]  = mk(1, 3, 32'h33,   1, 5, 32'h55,       1, 3, 32'h33,       0, 1);
        tbl[4]  = mk(1, 3, 32'h34,   0, 0, 0,            1, 3, 32'h34,       0, 1);
        tbl[5]  = mk(1, 3, 32'h35,   0, 0, 0,            1, 3, 32'h35,       0, 1);
        tbl[6]  = mk(1, 3, 32'h36,   0, 0, 0,            1, 3, 32'h36,       0, 1);
        tbl[7]  = mk(1, 3, 32'h37,   0, 0, 0,            1, 3, 32'h37,       0, 1);
        tbl[8]  = mk(1, 3, 32'h38,   0, 0, 0,            1, 5, 32'h55,       1, 1);
        tbl[9]  = mk(1, 3, 32'h38,   0, 0, 0,            1, 3, 32'h38,       0, 1);
        // x0 handling: pipeline rd0 leaves the port to the head; rd0 entry pops unwritten
        tbl[10] = mk(1, 4, 32'h40,   1, 9, 32'h99,       1, 4, 32'h40,       0, 1);
        tbl[11] = mk(1, 0, 32'hBAD,  0, 0, 0,            1, 9, 32'h99,       0, 1);
        tbl[12] = mk(0, 0, 0,        1, 0, 32'h1234,     0, 0, 0,            0, 1);
        tbl[13] = mk(0, 0, 0,        0, 0, 0,            0, 0, 32'h1234,     0, 1);
        tbl[14] = zero_rdy;
        // simultaneous push and pop
        tbl[15] = mk(0, 0, 0,        1, 10, 32'hA0,      0, 0, 0,            0, 1);
        tbl[16] = mk(0, 0, 0,        1, 11, 32'hB0,      1, 10, 32'hA0,      0, 1);
        tbl[17] = mk(0, 0, 0,        0, 0, 0,            1, 11, 32'hB0,      0, 1);
        tbl[18] = zero_rdy;

        // reset with a live pipeline write and long offer: everything forced low
        rst_n = 1'b0;
        drive(mk(1, 3, 32'h77, 1, 1, 32'h11, 0, 0, 0, 0, 0));
        #2;
        cmp(zero_nrdy, "reset_state");
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(zero_rdy);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cmp(zero_rdy, "reset_release");

        for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("vec%0d", i));

        // full queue: two accepts, third held off until after the forced pop
        step(mk(1, 3, 32'h300, 1, 20, 32'h200, 1, 3, 32'h300, 0, 1), "full_acc0");
        step(mk(1, 3, 32'h301, 1, 21, 32'h201, 1, 3, 32'h301, 0, 1), "full_acc1");
        for (int i = 2; i < 5; i++)
            step(mk(1, 3, 32'h300 + 32'(i), 1, 22, 32'h202, 1, 3, 32'h300 + 32'(i), 0, 0),
                 $sformatf("full_blk%0d", i));
        step(mk(1, 3, 32'h305, 1, 22, 32'h202, 1, 20, 32'h200, 1, 0), "full_force0");
        step(mk(1, 3, 32'h305, 1, 22, 32'h202, 1, 3,  32'h305, 0, 1), "full_acc2");
        for (int i = 7; i < 10; i++)
            step(mk(1, 3, 32'h300 + 32'(i), 0, 0, 0, 1, 3, 32'h300 + 32'(i), 0, 0),
                 $sformatf("full_blk%0d", i));
        step(mk(1, 3, 32'h30A, 0, 0, 0, 1, 21, 32'h201, 1, 0), "full_force1");
        step(mk(1, 3, 32'h30A, 0, 0, 0, 1, 3,  32'h30A, 0, 1), "full_held1");
        for (int i = 12; i < 15; i++)
            step(mk(1, 3, 32'h300 + 32'(i), 0, 0, 0, 1, 3, 32'h300 + 32'(i), 0, 1),
                 $sformatf("full_blk%0d", i));
        step(mk(1, 3, 32'h30F, 0, 0, 0, 1, 22, 32'h202, 1, 1), "full_force2");
        step(mk(1, 3, 32'h30F, 0, 0, 0, 1, 3,  32'h30F, 0, 1), "full_held2");

        // reset asserted in the middle of a forced drain
        step(mk(1, 3, 32'h400, 1, 12, 32'h120, 1, 3, 32'h400, 0, 1), "mrst_acc");
        for (int i = 1; i < 5; i++)
            step(mk(1, 3, 32'h400 + 32'(i), 0, 0, 0, 1, 3, 32'h400 + 32'(i), 0, 1),
                 $sformatf("mrst_blk%0d", i));
        step(mk(1, 3, 32'h405, 0, 0, 0, 1, 12, 32'h120, 1, 1), "mrst_force");
        #1;
        rst_n = 1'b0;
        #1;
        cmp(zero_nrdy, "mrst_immediate");
        #1;
        drive(zero_rdy);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        cmp(zero_rdy, "mrst_release");
        step(zero_rdy, "mrst_no_stale");
        step(mk(0, 0, 0, 1, 13, 32'h130, 0, 0, 0, 0, 1), "mrst_idle_acc");
        step(mk(0, 0, 0, 0, 0, 0, 1, 13, 32'h130, 0, 1), "mrst_idle_wr");
        step(zero_rdy, "mrst_idle_end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
